// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the conv_13 frame sequencer:
//   - FSM state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
//   - kernel register write addresses
//   - pixel / coefficient widths
//   - frame size helpers (pixels read per frame, results expected per frame)
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int unsigned PXL_W  = 8;
    localparam int unsigned COEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] COEF_ADDR_REG00 = 2'd0;
    localparam logic [1:0] COEF_ADDR_REG01 = 2'd1;
    localparam logic [1:0] COEF_ADDR_REG02 = 2'd2;
    localparam logic [1:0] COEF_ADDR_NONE  = 2'd3;

    // Number of input pixels streamed per frame.
    function automatic int unsigned calc_n_in(input int unsigned img_w,
                                              input int unsigned img_h);
        return img_w * img_h;
    endfunction

    // Number of valid-window results a KxK core produces per frame.
    function automatic int unsigned calc_n_out(input int unsigned img_w,
                                               input int unsigned img_h,
                                               input int unsigned k);
        return (img_w - k + 32'd1) * (img_h - k + 32'd1);
    endfunction

endpackage

// File: rtl/conv_frame_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_frame_addr_gen
// Raster read-address generator and the one-stage pixel pipeline to the core.
//   clk, reset   : clock, asynchronous active-low reset
//   start_fetch  : accepted frame start; begins reading at address 0
//   kill         : abort; stops reads and drops the pixel in flight
//   mem_data     : pixel returned by the input memory for the previous read
//   mem_rd       : read enable, high for exactly N_IN contiguous cycles
//   mem_addr     : read address (the read counter itself)
//   pxl_in/en    : pixel to the core, qualified one cycle after mem_rd
//   rd_last      : terminal count, high while the last address is issued
// -----------------------------------------------------------------------------
module conv_frame_addr_gen
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned N_IN   = 48400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_fetch,
    input  logic              kill,
    input  logic [PXL_W-1:0]  mem_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PXL_W-1:0]  pxl_in,
    output logic              pxl_en,
    output logic              rd_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(N_IN - 32'd1);
    localparam logic [ADDR_W-1:0] ADDR_ONE_C  = ADDR_W'(32'd1);

    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              mem_rd_q, mem_rd_d;
    logic              pxl_en_q, pxl_en_d;
    logic [PXL_W-1:0]  pxl_in_q, pxl_in_d;

    // The counter is presented directly as the address, so the terminal
    // flag is known in the same cycle the last address goes out.
    assign rd_last  = mem_rd_q && (rd_cnt_q == LAST_ADDR_C);
    assign mem_rd   = mem_rd_q;
    assign mem_addr = rd_cnt_q;
    assign pxl_en   = pxl_en_q;
    assign pxl_in   = pxl_in_q;

    // Next-state for the read counter and the pixel pipeline stage.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        mem_rd_d = mem_rd_q;
        pxl_en_d = mem_rd_q;
        pxl_in_d = pxl_in_q;
        if (kill) begin
            mem_rd_d = 1'b0;
            pxl_en_d = 1'b0;
        end else if (start_fetch) begin
            mem_rd_d = 1'b1;
            rd_cnt_d = '0;
        end else if (mem_rd_q) begin
            pxl_in_d = mem_data;
            if (rd_last) begin
                // Hold the counter on the last address; the frame is fully issued.
                mem_rd_d = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + ADDR_ONE_C;
            end
        end else begin
            pxl_in_d = pxl_in_q;
        end
    end

    // Read counter and pixel pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= '0;
            mem_rd_q <= 1'b0;
            pxl_en_q <= 1'b0;
            pxl_in_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            mem_rd_q <= mem_rd_d;
            pxl_en_q <= pxl_en_d;
            pxl_in_q <= pxl_in_d;
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// -----------------------------------------------------------------------------
// conv_frame_ctrl
// Frame sequencer for the conv_13 streaming 3x3 convolution core. Holds the
// three kernel/config registers, streams one IMG_W x IMG_H frame from the
// input memory to the core and writes every accepted core result to the
// output memory, then pulses done (or raises a sticky timeout).
//   clk, reset                 : clock, asynchronous active-low reset
//   start / abort              : frame start request / return to IDLE
//   coef_wr/addr/data          : kernel register write port (IDLE only)
//   reg_00..reg_02             : kernel/config registers to the core
//   mem_rd/mem_addr/mem_data   : input memory read port
//   pxl_in/pxl_en              : pixel stream to the core
//   core_valid/core_pxl        : results from the core
//   out_wr/out_addr/out_data   : output memory write port
//   busy/done/timeout          : status
// -----------------------------------------------------------------------------
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W     = 220,
    parameter int unsigned IMG_H     = 220,
    parameter int unsigned K         = 3,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DRAIN_MAX = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              coef_wr,
    input  logic [1:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [COEF_W-1:0] reg_00,
    output logic [COEF_W-1:0] reg_01,
    output logic [COEF_W-1:0] reg_02,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PXL_W-1:0]  mem_data,
    output logic [PXL_W-1:0]  pxl_in,
    output logic              pxl_en,
    input  logic              core_valid,
    input  logic [PXL_W-1:0]  core_pxl,
    output logic              out_wr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [PXL_W-1:0]  out_data,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int unsigned N_IN    = calc_n_in(IMG_W, IMG_H);
    localparam int unsigned N_OUT   = calc_n_out(IMG_W, IMG_H, K);
    localparam int unsigned DRAIN_W = (DRAIN_MAX > 32'd2) ? $clog2(DRAIN_MAX) : 32'd1;

    localparam logic [ADDR_W-1:0]  N_OUT_C      = ADDR_W'(N_OUT);
    localparam logic [ADDR_W-1:0]  ADDR_ONE_C   = ADDR_W'(32'd1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST_C = DRAIN_W'(DRAIN_MAX - 32'd1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE_C  = DRAIN_W'(32'd1);

    state_e             state_q,     state_d;
    logic [COEF_W-1:0]  reg_00_q,    reg_00_d;
    logic [COEF_W-1:0]  reg_01_q,    reg_01_d;
    logic [COEF_W-1:0]  reg_02_q,    reg_02_d;
    logic [ADDR_W-1:0]  out_cnt_q,   out_cnt_d;
    logic [ADDR_W-1:0]  out_addr_q,  out_addr_d;
    logic [PXL_W-1:0]   out_data_q,  out_data_d;
    logic               out_wr_q,    out_wr_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               timeout_q,   timeout_d;

    logic start_acc_s;
    logic wr_take_s;
    logic rd_last_s;

    // Abort outranks start, so a start is only accepted in IDLE without abort.
    assign start_acc_s = (state_q == ST_IDLE) && start && !abort;

    // Results are only taken while a frame is active and the quota is not met.
    assign wr_take_s = core_valid && !abort && (out_cnt_q != N_OUT_C) &&
                       ((state_q == ST_FETCH) || (state_q == ST_DRAIN));

    conv_frame_addr_gen #(
        .ADDR_W (ADDR_W),
        .N_IN   (N_IN)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .start_fetch (start_acc_s),
        .kill        (abort),
        .mem_data    (mem_data),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .pxl_in      (pxl_in),
        .pxl_en      (pxl_en),
        .rd_last     (rd_last_s)
    );

    // Next-state: FSM transitions, kernel register writes, output writer, status.
    always_comb begin
        state_d     = state_q;
        reg_00_d    = reg_00_q;
        reg_01_d    = reg_01_q;
        reg_02_d    = reg_02_q;
        out_cnt_d   = out_cnt_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_wr_d    = 1'b0;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;

        if (wr_take_s) begin
            out_wr_d   = 1'b1;
            out_data_d = core_pxl;
            out_addr_d = out_cnt_q;
            out_cnt_d  = out_cnt_q + ADDR_ONE_C;
        end else begin
            out_wr_d = 1'b0;
        end

        if (abort) begin
            // Timeout is left as-is; done is never raised for an aborted frame.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Kernel registers are writable only here, so they are
                    // frozen for the whole frame.
                    case ({coef_wr, coef_addr})
                        {1'b1, COEF_ADDR_REG00}: reg_00_d = coef_data;
                        {1'b1, COEF_ADDR_REG01}: reg_01_d = coef_data;
                        {1'b1, COEF_ADDR_REG02}: reg_02_d = coef_data;
                        default:                 reg_00_d = reg_00_q;
                    endcase
                    if (start_acc_s) begin
                        state_d     = ST_FETCH;
                        out_cnt_d   = '0;
                        out_addr_d  = '0;
                        drain_cnt_d = '0;
                        timeout_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (rd_last_s) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Completion wins over timeout when both land together.
                    if (out_cnt_q == N_OUT_C) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (drain_cnt_q == DRAIN_LAST_C) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_ONE_C;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    end

    // FSM state, kernel registers, output writer and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            reg_00_q    <= '0;
            reg_01_q    <= '0;
            reg_02_q    <= '0;
            out_cnt_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_wr_q    <= 1'b0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_00_q    <= reg_00_d;
            reg_01_q    <= reg_01_d;
            reg_02_q    <= reg_02_d;
            out_cnt_q   <= out_cnt_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_wr_q    <= out_wr_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign reg_00   = reg_00_q;
    assign reg_01   = reg_01_q;
    assign reg_02   = reg_02_q;
    assign out_wr   = out_wr_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule
